spi_mem_ctrl: RTL and testbench
===============================

// Module: spi_mem_ctrl
// PURPOSE
//  Single SPI master that serialises byte accesses from two requesters (instruction fetch, data
//  port) onto one SPI bus shared by a flash chip and a RAM chip. Issues 0x03 READ / 0x02 WRITE
//  with a 24-bit address, one data byte per transaction. Sits between the CPU core and the pads.
// PARAMETERS
//  CLK_DIV   1   clk cycles per spi_clk half-period (>=1); one SPI bit = 2*CLK_DIV clk cycles
// PORTS
//  clk            in   1   system clock
//  rst_n          in   1   asynchronous active-low reset
//  fetch_req      in   1   fetch read request; held high, address stable until fetch_ack
//  fetch_addr     in   16  fetch byte address
//  fetch_ack      out  1   1-cycle pulse: fetch done, fetch_rdata valid
//  fetch_rdata    out  8   fetch read data; held until next fetch_ack
//  mem_req        in   1   data-port request; held high, addr/we/wdata stable until mem_ack
//  mem_we         in   1   1 = write, 0 = read
//  mem_addr       in   16  data-port byte address
//  mem_wdata      in   8   write data
//  mem_ack        out  1   1-cycle pulse: data access done (read data valid if read)
//  mem_rdata      out  8   data-port read data; held until next read mem_ack
//  wr_err         out  1   1-cycle pulse with mem_ack when a write targeted flash
//  busy           out  1   high from request acceptance until the ack cycle inclusive
//  spi_clk        out  1   SPI clock, idles low (mode 0)
//  spi_mosi       out  1   master out, MSB first
//  spi_miso       in   1   slave out
//  spi_flash_ce_n out  1   flash chip enable, active low
//  spi_ram_ce_n   out  1   RAM chip enable, active low
// BEHAVIOUR
//  Reset: all acks/wr_err/busy 0, rdata regs 0x00, spi_clk 0, spi_mosi 0, both CE_n 1, FSM IDLE,
//   round-robin pointer = fetch. Reset mid-transaction: CE_n rise and spi_clk fall immediately
//   (async); no ack is ever issued for the aborted access.
//  Address map: addr[15]=0 -> flash, addr[15]=1 -> RAM; SPI address = {9'b0, addr[14:0]}.
//  FSM: IDLE -> SETUP -> SHIFT -> DONE -> IDLE.
//   IDLE: if any req, latch grant + addr/we/wdata; flash write -> DONE directly (no CE, no SPI).
//   SETUP (1 clk): selected CE_n low, spi_mosi = frame bit 39, spi_clk low.
//   SHIFT: 40-bit frame {cmd[7:0], addr[23:0], data[7:0]}, counter 39..0. Per bit: CLK_DIV clks
//    spi_clk low (mosi set at start), CLK_DIV clks spi_clk high. Read: on last clk of the high
//    half of bits 7..0, shift spi_miso into rdata shift reg. mosi = 0 during read data bits.
//   DONE (1 clk): spi_clk 0, both CE_n high, ack (+ rdata update on read, wr_err on flash write).
//  Latency (CLK_DIV=1): req sampled at edge t -> ack high in cycle t+82 (1 SETUP + 80 SHIFT + 1).
//   General: 2 + 80*CLK_DIV. Flash write: ack + wr_err at t+1.
//  CE_n high >=2 clk between transactions (DONE + IDLE); exactly one CE_n low at any time.
//  Arbitration in IDLE: single req wins; both pending -> grant the one NOT granted last
//   (pointer updates on every grant). Ack never asserted for a requester not granted.
//  req dropped before ack: illegal; controller completes the latched access and acks anyway.
//  rdata of the other port is never disturbed; write ack leaves mem_rdata unchanged.
// TESTING (bench: two tb_spi_memory models, flash is_flash=1, RAM is_flash=0; CLK_DIV=1)
//  fetch 0x0000 -> fetch_ack at t+82, fetch_rdata=0x3E; spi_flash_ce_n low 81 clk, RAM CE_n 1.
//  fetch 0x0008 -> 0xC2; frame on mosi = 0x03,0x00,0x00,0x08 MSB first; 40 spi_clk rising edges.
//  mem write 0x8005=0xA5 then mem read 0x8005 -> RAM model prints write; mem_rdata=0xA5.
//  fetch_req & mem_req same cycle, held -> fetch served first, then mem; CE_n high 2 clk between.
//  mem write 0x0003 (flash) -> mem_ack+wr_err at t+1, both CE_n stay 1, no model $error.
//  rst_n low at bit 20 of a read -> CE_n=1, spi_clk=0 same cycle, no ack; next fetch correct.

Source files
------------

// File: rtl/spi_mem_ctrl.sv
// spi_mem_ctrl: SPI master serialising fetch and data-port byte accesses onto a shared flash + RAM bus
// Ports:
//   clk, rst_n                            system clock, asynchronous active-low reset
//   fetch_req/fetch_addr                  instruction-fetch read request (held until fetch_ack)
//   fetch_ack/fetch_rdata                 fetch completion pulse and held read data
//   mem_req/mem_we/mem_addr/mem_wdata     data-port request (held until mem_ack)
//   mem_ack/mem_rdata/wr_err              data-port completion, held read data, flash-write error pulse
//   busy                                  high from request acceptance through the ack cycle
//   spi_clk/spi_mosi/spi_miso             mode-0 SPI bus, MSB first
//   spi_flash_ce_n/spi_ram_ce_n           chip enables; addr[15] selects RAM
module spi_mem_ctrl #(
  parameter int CLK_DIV = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_req,
  input  logic [15:0] fetch_addr,
  output logic        fetch_ack,
  output logic [7:0]  fetch_rdata,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [15:0] mem_addr,
  input  logic [7:0]  mem_wdata,
  output logic        mem_ack,
  output logic [7:0]  mem_rdata,
  output logic        wr_err,
  output logic        busy,
  output logic        spi_clk,
  output logic        spi_mosi,
  input  logic        spi_miso,
  output logic        spi_flash_ce_n,
  output logic        spi_ram_ce_n
);
  localparam int DW = $clog2(2 * CLK_DIV);
  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, DONE} state_t;
  state_t state, state_n;
  logic          g_mem, we_q, prio_mem;
  logic [15:0]   addr_q;
  logic [7:0]    wdata_q;
  logic [5:0]    bit_cnt;
  logic [DW-1:0] div_cnt;
  logic [6:0]    sh;
  logic          any_req, pick_mem, flash_wr, last_tick, sel;
  logic [39:0]   frame;
  // Round robin: when both request, prio_mem says the data port was not granted last
  assign any_req   = fetch_req | mem_req;
  assign pick_mem  = mem_req & (~fetch_req | prio_mem);
  assign flash_wr  = pick_mem & mem_we & ~mem_addr[15];
  assign last_tick = div_cnt == DW'(2 * CLK_DIV - 1);
  assign sel       = state == SETUP || state == SHIFT;
  // Read frames carry zero data bits so mosi stays low while the slave returns data
  assign frame     = {we_q ? 8'h02 : 8'h03, 9'b0, addr_q[14:0], we_q ? wdata_q : 8'h00};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_comb
    state_n = state == IDLE  ? (any_req ? (flash_wr ? DONE : SETUP) : IDLE)
            : state == SETUP ? SHIFT
            : state == SHIFT ? (last_tick && bit_cnt == 6'd0 ? DONE : SHIFT)
            : IDLE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      g_mem       <= 1'b0;
      we_q        <= 1'b0;
      prio_mem    <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      bit_cnt     <= 6'd39;
      div_cnt     <= '0;
      sh          <= '0;
      fetch_rdata <= '0;
      mem_rdata   <= '0;
    end else begin
      if (state == IDLE && any_req) begin
        g_mem    <= pick_mem;
        prio_mem <= ~pick_mem;
        we_q     <= pick_mem & mem_we;
        addr_q   <= pick_mem ? mem_addr : fetch_addr;
        wdata_q  <= mem_wdata;
      end
      bit_cnt <= state == SHIFT ? (last_tick ? bit_cnt - 6'd1 : bit_cnt) : 6'd39;
      div_cnt <= state == SHIFT && !last_tick ? div_cnt + DW'(1) : '0;
      // Sample at the end of the high half, before the slave shifts its next bit out
      if (state == SHIFT && last_tick && bit_cnt < 6'd8) sh <= {sh[5:0], spi_miso};
      if (state == SHIFT && last_tick && bit_cnt == 6'd0 && !we_q) begin
        if (g_mem) mem_rdata <= {sh, spi_miso};
        else fetch_rdata <= {sh, spi_miso};
      end
    end
  always_comb begin
    busy           = state != IDLE;
    fetch_ack      = state == DONE && !g_mem;
    mem_ack        = state == DONE && g_mem;
    wr_err         = state == DONE && g_mem && we_q && !addr_q[15];
    spi_flash_ce_n = !(sel && !addr_q[15]);
    spi_ram_ce_n   = !(sel && addr_q[15]);
    spi_clk        = state == SHIFT && div_cnt >= DW'(CLK_DIV);
    spi_mosi       = sel && frame[bit_cnt];
  end
endmodule

// File: tb/tb_spi_mem_ctrl.sv
// tb_spi_mem_ctrl: randomized check of spi_mem_ctrl against flash/RAM SPI slaves and an array reference model
module tb_spi_mem_ctrl;
  logic        clk = 0, rst_n = 0;
  logic        fetch_req = 0, mem_req = 0, mem_we = 0;
  logic [15:0] fetch_addr = 0, mem_addr = 0;
  logic [7:0]  mem_wdata = 0;
  logic        fetch_ack, mem_ack, wr_err, busy, spi_clk, spi_mosi, spi_miso;
  logic        spi_flash_ce_n, spi_ram_ce_n;
  logic [7:0]  fetch_rdata, mem_rdata;
  int errs = 0, checks = 0;
  always #5 clk = ~clk;
  spi_mem_ctrl #(.CLK_DIV(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ack(fetch_ack), .fetch_rdata(fetch_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .wr_err(wr_err), .busy(busy),
    .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
    .spi_flash_ce_n(spi_flash_ce_n), .spi_ram_ce_n(spi_ram_ce_n)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // SPI slaves: flash and RAM share one decoder since only one CE may be low
  logic [7:0]  flash_m [32768];
  logic [7:0]  ram_m   [32768];
  logic [7:0]  ref_ram [32768];
  logic        ce_idle, miso_q = 0, flash_wr_seen = 0;
  logic [39:0] rx = 0;
  logic [31:0] last_hdr = 0;
  int          nbits = 0, last_nbits = 0;
  assign ce_idle  = spi_flash_ce_n & spi_ram_ce_n;
  assign spi_miso = ce_idle ? 1'b0 : miso_q;
  always @(posedge spi_clk or posedge ce_idle)
    if (ce_idle) begin
      last_nbits <= nbits;
      nbits      <= 0;
    end else begin
      rx    <= {rx[38:0], spi_mosi};
      nbits <= nbits + 1;
      if (nbits == 31) last_hdr <= {rx[30:0], spi_mosi};
      if (nbits == 39 && rx[38:31] == 8'h02) begin
        if (!spi_ram_ce_n) begin
          ram_m[rx[21:7]] <= {rx[6:0], spi_mosi};
          $display("RAM model: write [%h] = %h", rx[21:7], {rx[6:0], spi_mosi});
        end else flash_wr_seen <= 1;
      end
    end
  always @(negedge spi_clk)
    if (!ce_idle && nbits >= 32 && nbits < 40 && last_hdr[31:24] == 8'h03)
      miso_q <= 1'((spi_ram_ce_n ? flash_m[last_hdr[14:0]] : ram_m[last_hdr[14:0]]) >> (39 - nbits));
  // Chip-enable monitor: low-period length, selected chip, gap and exclusivity violations
  int   low_len = 0, gap = 100, last_low = 0, ce_viol = 0;
  logic last_ram = 0;
  always @(negedge clk)
    if (!ce_idle) begin
      if ((!spi_flash_ce_n && !spi_ram_ce_n) || (low_len == 0 && gap < 2)) ce_viol <= ce_viol + 1;
      low_len  <= low_len + 1;
      gap      <= 0;
      last_ram <= !spi_ram_ce_n;
    end else begin
      if (low_len != 0 && rst_n) last_low <= low_len;
      low_len <= 0;
      gap     <= gap + 1;
    end
  // Reference model: byte arrays, round-robin memory, and latency rules
  bit         last_mem = 1;
  logic [7:0] exp_frd = 0, exp_mrd = 0;
  function automatic logic [7:0] ref_rd(input logic [15:0] a);
    return a[15] ? ref_ram[a[14:0]] : flash_m[a[14:0]];
  endfunction
  task automatic run(input bit f, input bit m, input logic [15:0] fa, input logic [15:0] ma,
                     input bit we, input logic [7:0] wd);
    int  ef, em, lm, lim;
    bit  mem_first, fseen, mseen, fw;
    fw = m && we && !ma[15];
    lm = fw ? 1 : 82;
    mem_first = m && (!f || !last_mem);
    ef = 0; em = 0; fseen = 0; mseen = 0;
    if (mem_first) begin em = lm; if (f) ef = lm + 1 + 82; end
    else begin if (f) ef = 82; if (m) em = (f ? 83 : 0) + lm; end
    last_mem = f && m ? !mem_first : m;
    lim = (ef > em ? ef : em) + 3;
    fetch_req = f; fetch_addr = fa;
    mem_req = m; mem_we = we; mem_addr = ma; mem_wdata = wd;
    for (int c = 1; c <= lim; c++) begin
      @(negedge clk);
      if (fetch_ack) begin
        chk("fetch_lat", c, ef);
        chk("fetch_busy", busy, 1);
        chk("fetch_rdata", fetch_rdata, ref_rd(fa));
        chk("mem_rdata_kept", mem_rdata, exp_mrd);
        exp_frd = ref_rd(fa); fseen = 1; fetch_req = 0;
      end
      if (mem_ack) begin
        chk("mem_lat", c, em);
        chk("mem_busy", busy, 1);
        chk("wr_err", wr_err, fw);
        if (!we) exp_mrd = ref_rd(ma);
        else if (ma[15]) ref_ram[ma[14:0]] = wd;
        chk("mem_rdata", mem_rdata, exp_mrd);
        chk("fetch_rdata_kept", fetch_rdata, exp_frd);
        mseen = 1; mem_req = 0;
      end
    end
    chk("fetch_seen", fseen, f);
    chk("mem_seen", mseen, m);
    chk("busy_idle", busy, 0);
    chk("ce_rules", ce_viol, 0);
    if (f != m && !fw) begin
      chk("hdr", last_hdr, {m && we ? 8'h02 : 8'h03, 9'b0, m ? ma[14:0] : fa[14:0]});
      chk("spi_edges", last_nbits, 40);
      chk("ce_low", last_low, 81);
      chk("ce_sel", last_ram, m ? ma[15] : fa[15]);
    end
  endtask
  initial begin
    for (int i = 0; i < 32768; i++) begin
      flash_m[i] = 8'($urandom);
      ram_m[i]   = 8'($urandom);
      ref_ram[i] = ram_m[i];
    end
    flash_m[0] = 8'h3E;
    flash_m[8] = 8'hC2;
    repeat (3) @(negedge clk);
    chk("rst_acks", {fetch_ack, mem_ack, wr_err, busy}, 0);
    chk("rst_rdata", {fetch_rdata, mem_rdata}, 0);
    chk("rst_spi", {spi_clk, spi_mosi, spi_flash_ce_n, spi_ram_ce_n}, 4'b0011);
    rst_n = 1;
    @(negedge clk);
    run(1, 0, 16'h0000, 0, 0, 0);
    chk("fetch_0000", fetch_rdata, 8'h3E);
    run(1, 0, 16'h0008, 0, 0, 0);
    chk("fetch_0008", fetch_rdata, 8'hC2);
    chk("hdr_0008", last_hdr, 32'h03000008);
    run(0, 1, 0, 16'h8005, 1, 8'hA5);
    run(0, 1, 0, 16'h8005, 0, 0);
    chk("ram_8005", mem_rdata, 8'hA5);
    run(1, 1, 16'h0010, 16'h8005, 0, 0);
    run(0, 1, 0, 16'h0003, 1, 8'h5A);
    for (int i = 0; i < 30; i++) begin
      int sel = $urandom_range(1, 3);
      run(sel[0], sel[1], 16'($urandom), 16'($urandom), 1'($urandom), 8'($urandom));
    end
    chk("flash_no_write", flash_wr_seen, 0);
    fetch_req = 1; fetch_addr = 16'h0123;
    for (int i = 0; i < 200 && nbits < 20; i++) @(negedge clk);
    chk("abort_bit20", nbits, 20);
    #2 rst_n = 0;
    #1 chk("abort_spi", {spi_clk, spi_flash_ce_n, spi_ram_ce_n}, 3'b011);
    fetch_req = 0;
    repeat (3) begin
      @(negedge clk);
      chk("abort_noack", {fetch_ack, mem_ack}, 0);
    end
    rst_n = 1;
    last_mem = 1; exp_frd = 0; exp_mrd = 0;
    chk("abort_rdata", {fetch_rdata, mem_rdata}, 0);
    @(negedge clk);
    run(1, 0, 16'h0008, 0, 0, 0);
    chk("post_abort_fetch", fetch_rdata, 8'hC2);
    run(1, 1, 16'h8005, 16'h0000, 0, 0);
    chk("post_abort_mem", mem_rdata, 8'h3E);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
